// File: rtl/core_pkg.sv
// Shared definitions for the RV64 core front end: widths, reset defaults,
// the bubble encoding and the fetch FSM state type.
package core_pkg;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    // Instruction addresses are word aligned; the low two bits are simply cleared.
    function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
        return pc & ~{{(XLEN-2){1'b0}}, 2'b11};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory bus: valid/ready request channel plus a valid-only response channel.
interface fetch_stage_if
    import core_pkg::*;
();

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] addr;
    logic            rsp_valid;
    logic [31:0]     rdata;

    modport master (
        output req_valid,
        output addr,
        input  req_ready,
        input  rsp_valid,
        input  rdata
    );

    modport slave (
        input  req_valid,
        input  addr,
        output req_ready,
        output rsp_valid,
        output rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// Generic pipeline register between two stages with reset, flush (bubble insert),
// load and implicit hold when neither flush nor load is asserted.
module if_id_reg
    import core_pkg::*;
#(
    parameter int          W   = XLEN,
    parameter logic [31:0] NOP = NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         flush_i,
    input  logic [31:0]  instr_i,
    input  logic [W-1:0] pc_i,
    input  logic [W-1:0] pcPlus4_i,
    output logic [31:0]  instr_o,
    output logic [W-1:0] pc_o,
    output logic [W-1:0] pcPlus4_o,
    output logic         valid_o
);

    logic [31:0]  instr_q;
    logic [W-1:0] pc_q;
    logic [W-1:0] pcPlus4_q;
    logic         valid_q;

    // Flush outranks load so a redirect always wins over an arriving instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= NOP;
            pc_q      <= '0;
            pcPlus4_q <= '0;
            valid_q   <= 1'b0;
        end else if (flush_i) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q   <= instr_i;
            pc_q      <= pc_i;
            pcPlus4_q <= pcPlus4_i;
            valid_q   <= 1'b1;
        end
    end

    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign pcPlus4_o = pcPlus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV64 fetch stage: owns the PC, issues one outstanding fetch at a time and
// fills the IF/ID register, absorbing decode stalls and execute redirects.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    fetch_stage_if.master    imem,
    input  logic             stallD,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [31:0]      instrD,
    output logic [XLEN-1:0]  pcD,
    output logic [XLEN-1:0]  pc_plus4D,
    output logic             validD
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     skid_q, skid_d;
    logic            ifIdLoad;
    logic            ifIdFlush;
    logic [XLEN-1:0] pcPlus4;
    logic [31:0]     ifIdInstr;

    assign pcPlus4        = pc_q + XLEN'(4);
    assign ifIdInstr      = (state_q == HOLD) ? skid_q : imem.rdata;
    assign imem.req_valid = (state_q == REQ) && !rst;
    assign imem.addr      = pc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        skid_d    = skid_q;
        ifIdLoad  = 1'b0;
        ifIdFlush = 1'b0;

        case (state_q)
            REQ: begin
                if (imem.req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (imem.rsp_valid) begin
                    if (stallD) begin
                        skid_d  = imem.rdata;
                        state_d = HOLD;
                    end else begin
                        ifIdLoad = 1'b1;
                        pc_d     = pcPlus4;
                        state_d  = REQ;
                    end
                end
            end
            HOLD: begin
                if (!stallD) begin
                    ifIdLoad = 1'b1;
                    pc_d     = pcPlus4;
                    state_d  = REQ;
                end
            end
            DROP: begin
                if (imem.rsp_valid) state_d = REQ;
            end
            default: state_d = REQ;
        endcase

        // A redirect kills whatever is in flight; a request the memory has taken
        // but not yet answered must have its response swallowed in DROP.
        if (redirect_valid) begin
            ifIdLoad  = 1'b0;
            ifIdFlush = 1'b1;
            skid_d    = '0;
            pc_d      = alignPc(redirect_pc);
            case (state_q)
                REQ:     state_d = imem.req_ready ? DROP : REQ;
                WAIT:    state_d = imem.rsp_valid ? REQ : DROP;
                DROP:    state_d = imem.rsp_valid ? REQ : DROP;
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
        end
    end

    if_id_reg #(
        .W   (XLEN),
        .NOP (NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (ifIdLoad),
        .flush_i   (ifIdFlush),
        .instr_i   (ifIdInstr),
        .pc_i      (pc_q),
        .pcPlus4_i (pcPlus4),
        .instr_o   (instrD),
        .pc_o      (pcD),
        .pcPlus4_o (pc_plus4D),
        .valid_o   (validD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays the instruction memory cycle by cycle.
module tb_fetch_stage;
    import core_pkg::*;

    logic            clk;
    logic            rst;
    logic            stallD;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     instrD;
    logic [XLEN-1:0] pcD;
    logic [XLEN-1:0] pc_plus4D;
    logic            validD;

    int checks;
    int failures;

    fetch_stage_if imemBus();

    fetch_stage #(
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imemBus),
        .stallD         (stallD),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instrD         (instrD),
        .pcD            (pcD),
        .pc_plus4D      (pc_plus4D),
        .validD         (validD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (imemBus.req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_valid actual=%0h expected=0", imemBus.req_valid); end
        checks++; if (validD !== 1'b0) begin failures++; $display("[TB] FAIL reset_validD actual=%0h expected=0", validD); end
        checks++; if (instrD !== 32'h0000_0013) begin failures++; $display("[TB] FAIL reset_instrD actual=%h expected=00000013", instrD); end
        checks++; if (pcD !== 64'h0) begin failures++; $display("[TB] FAIL reset_pcD actual=%h expected=0", pcD); end
        checks++; if (pc_plus4D !== 64'h0) begin failures++; $display("[TB] FAIL reset_pc_plus4D actual=%h expected=0", pc_plus4D); end
        rst = 1'b0;
        #1;
        checks++; if (imemBus.req_valid !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_req_valid actual=%0h expected=1", imemBus.req_valid); end
        checks++; if (imemBus.addr !== 64'h0) begin failures++; $display("[TB] FAIL post_reset_addr actual=%h expected=0", imemBus.addr); end
    endtask

    task automatic test_basic_fetch();
        imemBus.req_ready = 1'b1;
        tick();
        imemBus.req_ready = 1'b0;
        checks++; if (imemBus.req_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_wait_req_valid actual=%0h expected=0", imemBus.req_valid); end
        imemBus.rsp_valid = 1'b1;
        imemBus.rdata     = 32'h00A0_0093;
        tick();
        imemBus.rsp_valid = 1'b0;
        checks++; if (instrD !== 32'h00A0_0093) begin failures++; $display("[TB] FAIL basic_instrD actual=%h expected=00a00093", instrD); end
        checks++; if (pcD !== 64'h0) begin failures++; $display("[TB] FAIL basic_pcD actual=%h expected=0", pcD); end
        checks++; if (pc_plus4D !== 64'h4) begin failures++; $display("[TB] FAIL basic_pc_plus4D actual=%h expected=4", pc_plus4D); end
        checks++; if (validD !== 1'b1) begin failures++; $display("[TB] FAIL basic_validD actual=%0h expected=1", validD); end
        checks++; if (imemBus.req_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_next_req_valid actual=%0h expected=1", imemBus.req_valid); end
        checks++; if (imemBus.addr !== 64'h4) begin failures++; $display("[TB] FAIL basic_next_addr actual=%h expected=4", imemBus.addr); end
    endtask

    task automatic test_stall();
        imemBus.req_ready = 1'b1;
        tick();
        imemBus.req_ready = 1'b0;
        stallD            = 1'b1;
        imemBus.rsp_valid = 1'b1;
        imemBus.rdata     = 32'h0020_8113;
        tick();
        imemBus.rsp_valid = 1'b0;
        imemBus.rdata     = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (instrD !== 32'h00A0_0093) begin failures++; $display("[TB] FAIL stall_instrD_hold[%0d] actual=%h expected=00a00093", i, instrD); end
            checks++; if (pcD !== 64'h0) begin failures++; $display("[TB] FAIL stall_pcD_hold[%0d] actual=%h expected=0", i, pcD); end
            checks++; if (validD !== 1'b1) begin failures++; $display("[TB] FAIL stall_validD_hold[%0d] actual=%0h expected=1", i, validD); end
            checks++; if (imemBus.req_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_no_req[%0d] actual=%0h expected=0", i, imemBus.req_valid); end
            if (i < 2) tick();
        end
        stallD = 1'b0;
        tick();
        checks++; if (instrD !== 32'h0020_8113) begin failures++; $display("[TB] FAIL stall_release_instrD actual=%h expected=00208113", instrD); end
        checks++; if (pcD !== 64'h4) begin failures++; $display("[TB] FAIL stall_release_pcD actual=%h expected=4", pcD); end
        checks++; if (pc_plus4D !== 64'h8) begin failures++; $display("[TB] FAIL stall_release_pc_plus4D actual=%h expected=8", pc_plus4D); end
        checks++; if (validD !== 1'b1) begin failures++; $display("[TB] FAIL stall_release_validD actual=%0h expected=1", validD); end
        checks++; if (imemBus.addr !== 64'h8) begin failures++; $display("[TB] FAIL stall_release_addr actual=%h expected=8", imemBus.addr); end
        checks++; if (imemBus.req_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_release_req_valid actual=%0h expected=1", imemBus.req_valid); end
    endtask

    task automatic test_redirect_wait();
        imemBus.req_ready = 1'b1;
        tick();
        imemBus.req_ready = 1'b0;
        redirect_valid    = 1'b1;
        redirect_pc       = 64'h1000;
        tick();
        redirect_valid = 1'b0;
        checks++; if (instrD !== 32'h0000_0013) begin failures++; $display("[TB] FAIL redir_wait_instrD actual=%h expected=00000013", instrD); end
        checks++; if (validD !== 1'b0) begin failures++; $display("[TB] FAIL redir_wait_validD actual=%0h expected=0", validD); end
        checks++; if (imemBus.req_valid !== 1'b0) begin failures++; $display("[TB] FAIL redir_drop_req_valid actual=%0h expected=0", imemBus.req_valid); end
        imemBus.rsp_valid = 1'b1;
        imemBus.rdata     = 32'hDEAD_BEEF;
        tick();
        imemBus.rsp_valid = 1'b0;
        checks++; if (instrD !== 32'h0000_0013) begin failures++; $display("[TB] FAIL redir_late_rsp_instrD actual=%h expected=00000013", instrD); end
        checks++; if (validD !== 1'b0) begin failures++; $display("[TB] FAIL redir_late_rsp_validD actual=%0h expected=0", validD); end
        checks++; if (imemBus.req_valid !== 1'b1) begin failures++; $display("[TB] FAIL redir_target_req_valid actual=%0h expected=1", imemBus.req_valid); end
        checks++; if (imemBus.addr !== 64'h1000) begin failures++; $display("[TB] FAIL redir_target_addr actual=%h expected=1000", imemBus.addr); end
        imemBus.req_ready = 1'b1;
        tick();
        imemBus.req_ready = 1'b0;
        imemBus.rsp_valid = 1'b1;
        imemBus.rdata     = 32'h0030_0193;
        tick();
        imemBus.rsp_valid = 1'b0;
        checks++; if (instrD !== 32'h0030_0193) begin failures++; $display("[TB] FAIL redir_fetch_instrD actual=%h expected=00300193", instrD); end
        checks++; if (pcD !== 64'h1000) begin failures++; $display("[TB] FAIL redir_fetch_pcD actual=%h expected=1000", pcD); end
        checks++; if (pc_plus4D !== 64'h1004) begin failures++; $display("[TB] FAIL redir_fetch_pc_plus4D actual=%h expected=1004", pc_plus4D); end
        checks++; if (imemBus.addr !== 64'h1004) begin failures++; $display("[TB] FAIL redir_fetch_next_addr actual=%h expected=1004", imemBus.addr); end
    endtask

    task automatic test_redirect_stall();
        imemBus.req_ready = 1'b1;
        tick();
        imemBus.req_ready = 1'b0;
        stallD            = 1'b1;
        imemBus.rsp_valid = 1'b1;
        imemBus.rdata     = 32'h0040_0213;
        redirect_valid    = 1'b1;
        redirect_pc       = 64'h2000;
        tick();
        stallD            = 1'b0;
        imemBus.rsp_valid = 1'b0;
        redirect_valid    = 1'b0;
        checks++; if (validD !== 1'b0) begin failures++; $display("[TB] FAIL redir_stall_validD actual=%0h expected=0", validD); end
        checks++; if (instrD !== 32'h0000_0013) begin failures++; $display("[TB] FAIL redir_stall_instrD actual=%h expected=00000013", instrD); end
        checks++; if (imemBus.req_valid !== 1'b1) begin failures++; $display("[TB] FAIL redir_stall_req_valid actual=%0h expected=1", imemBus.req_valid); end
        checks++; if (imemBus.addr !== 64'h2000) begin failures++; $display("[TB] FAIL redir_stall_addr actual=%h expected=2000", imemBus.addr); end
        imemBus.req_ready = 1'b1;
        redirect_valid    = 1'b1;
        redirect_pc       = 64'h3000;
        tick();
        imemBus.req_ready = 1'b0;
        redirect_valid    = 1'b0;
        checks++; if (imemBus.req_valid !== 1'b0) begin failures++; $display("[TB] FAIL redir_accept_drop_req_valid actual=%0h expected=0", imemBus.req_valid); end
        imemBus.rsp_valid = 1'b1;
        imemBus.rdata     = 32'hBAD0_0BAD;
        tick();
        imemBus.rsp_valid = 1'b0;
        checks++; if (imemBus.addr !== 64'h3000) begin failures++; $display("[TB] FAIL redir_accept_target_addr actual=%h expected=3000", imemBus.addr); end
        checks++; if (validD !== 1'b0) begin failures++; $display("[TB] FAIL redir_accept_validD actual=%0h expected=0", validD); end
    endtask

    task automatic test_align_and_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1003;
        tick();
        checks++; if (imemBus.addr !== 64'h1000) begin failures++; $display("[TB] FAIL align_addr actual=%h expected=1000", imemBus.addr); end
        checks++; if (imemBus.req_valid !== 1'b1) begin failures++; $display("[TB] FAIL align_req_valid actual=%0h expected=1", imemBus.req_valid); end
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imemBus.addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_start_addr actual=%h expected=fffffffffffffffc", imemBus.addr); end
        imemBus.req_ready = 1'b1;
        tick();
        imemBus.req_ready = 1'b0;
        imemBus.rsp_valid = 1'b1;
        imemBus.rdata     = 32'h0000_006F;
        tick();
        imemBus.rsp_valid = 1'b0;
        checks++; if (pcD !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_pcD actual=%h expected=fffffffffffffffc", pcD); end
        checks++; if (pc_plus4D !== 64'h0) begin failures++; $display("[TB] FAIL wrap_pc_plus4D actual=%h expected=0", pc_plus4D); end
        checks++; if (validD !== 1'b1) begin failures++; $display("[TB] FAIL wrap_validD actual=%0h expected=1", validD); end
        checks++; if (imemBus.addr !== 64'h0) begin failures++; $display("[TB] FAIL wrap_next_addr actual=%h expected=0", imemBus.addr); end
    endtask

    task automatic test_ready_low_and_reset();
        imemBus.req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (imemBus.req_valid !== 1'b1) begin failures++; $display("[TB] FAIL backpressure_req_valid[%0d] actual=%0h expected=1", i, imemBus.req_valid); end
            checks++; if (imemBus.addr !== 64'h0) begin failures++; $display("[TB] FAIL backpressure_addr[%0d] actual=%h expected=0", i, imemBus.addr); end
        end
        imemBus.req_ready = 1'b1;
        tick();
        imemBus.req_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++; if (validD !== 1'b0) begin failures++; $display("[TB] FAIL midwait_reset_validD actual=%0h expected=0", validD); end
        checks++; if (instrD !== 32'h0000_0013) begin failures++; $display("[TB] FAIL midwait_reset_instrD actual=%h expected=00000013", instrD); end
        checks++; if (imemBus.req_valid !== 1'b0) begin failures++; $display("[TB] FAIL midwait_reset_req_valid actual=%0h expected=0", imemBus.req_valid); end
        rst = 1'b0;
        imemBus.rsp_valid = 1'b1;
        imemBus.rdata     = 32'h1234_5678;
        #1;
        checks++; if (imemBus.addr !== 64'h0) begin failures++; $display("[TB] FAIL midwait_reset_addr actual=%h expected=0", imemBus.addr); end
        checks++; if (imemBus.req_valid !== 1'b1) begin failures++; $display("[TB] FAIL midwait_reset_req_again actual=%0h expected=1", imemBus.req_valid); end
        tick();
        imemBus.rsp_valid = 1'b0;
        checks++; if (validD !== 1'b0) begin failures++; $display("[TB] FAIL stale_rsp_after_reset_validD actual=%0h expected=0", validD); end
        checks++; if (imemBus.addr !== 64'h0) begin failures++; $display("[TB] FAIL stale_rsp_after_reset_addr actual=%h expected=0", imemBus.addr); end
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst               = 1'b1;
        stallD            = 1'b0;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
        imemBus.req_ready = 1'b0;
        imemBus.rsp_valid = 1'b0;
        imemBus.rdata     = '0;

        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_stall();
        test_align_and_wrap();
        test_ready_low_and_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
